fetch_queue: RTL and testbench

- Instruction prefetch buffer between the IF-stage PC/InstructionMemory fetch path and the IF/ID pipeline register.
- Decouples fetch from decode stalls: fetch keeps filling while decode holds (load-use hazard).
- On a branch redirect (PC mux select taken), the queue flushes all wrong-path entries.
- Each entry carries {PC+4, instruction}.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_ram.sv | 29 ++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_pkg
// Brief  : Shared constants and helpers for the instruction prefetch queue.
// Rev    : 1.0
// ============================================================================
package fetch_queue_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000000;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_ram
// Brief  : Entry storage; synchronous write, asynchronous read, no reset.
// Rev    : 1.0
// ============================================================================
module fetch_queue_ram #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [PTR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [PTR_W-1:0] rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) r_mem[wrAddr] <= wrData;
  end

  assign rdData = r_mem[rdAddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : Instruction prefetch FIFO between fetch and IF/ID, flushed on redirect.
// Rev    : 1.0
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_instr,
  output logic              in_ready,
  input  logic              out_pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_instr,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]    r_rdPtr;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W:0]      r_count;
  logic                w_push;
  logic                w_pop;
  logic [2*DATA_W-1:0] w_head;

  assign full     = (r_count == C_DEPTH);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign in_ready = ~full;
  assign out_valid = ~empty;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign w_push = in_valid & ~full;
  assign w_pop  = out_pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (2*DATA_W)
  ) u_ram (
    .clk    (clk),
    .wrEn   (w_push & ~flush),
    .wrAddr (r_wrPtr),
    .wrData ({in_pc4, in_instr}),
    .rdAddr (r_rdPtr),
    .rdData (w_head)
  );

  assign out_pc4   = empty ? '0 : w_head[2*DATA_W-1:DATA_W];
  assign out_instr = empty ? DATA_W'(NOP_INSTR) : w_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_queue
// Brief  : Randomized and directed bench for fetch_queue against a queue model.
// Rev    : 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int VW    = 3 + 4 + 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc4 = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_pop = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc4    (in_pc4),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_pop   (out_pop),
    .out_valid (out_valid),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] expv();
    int sz;
    logic [63:0] head;
    sz = mq.size();
    head = (sz != 0) ? mq[0] : 64'h0;
    return {3'(sz), sz == DEPTH, sz == 0, sz != 0, sz != DEPTH, head};
  endfunction

  function automatic logic [VW-1:0] dutv();
    return {count, full, empty, out_valid, in_ready, out_pc4, out_instr};
  endfunction

  // Advance one clock; the model applies FIFO rules to the inputs seen before the edge.
  task automatic cycle();
    bit pu, po;
    pu = in_valid && (mq.size() < DEPTH);
    po = out_pop && (mq.size() > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({in_pc4, in_instr});
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit p, input bit f, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v; out_pop = p; flush = f; in_pc4 = pc; in_instr = ins;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    mq.delete();
    @(posedge clk); #1;
    checks++;
    if (dutv() !== expv()) begin errors++; $display("FAIL reset_state got %h want %h", dutv(), expv()); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h4, 32'hDEADBEEF);
      cycle();
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || out_instr !== 32'h0 || out_pc4 !== 32'h0) begin
        errors++; $display("FAIL reset_idle count %0d empty %b instr %h pc4 %h want 0 1 0 0", count, empty, out_instr, out_pc4);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] ins [4];
    ins[0] = 32'h20080005; ins[1] = 32'h20090007; ins[2] = 32'h01095020; ins[3] = 32'hAC0A0000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'(4 * (i + 1)), ins[i]);
      cycle();
      checks++;
      if (count !== 3'(i + 1) || dutv() !== expv()) begin
        errors++; $display("FAIL fill_%0d got %h want %h", i, dutv(), expv());
      end
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full full %b ready %b want 1 0", full, in_ready); end
    drive(1, 0, 0, 32'd20, 32'h8C0B0000);
    cycle();
    checks++;
    if (count !== 3'd4 || out_instr !== 32'h20080005) begin
      errors++; $display("FAIL fifth_push count %0d head %h want 4 20080005", count, out_instr);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_instr !== ins[i] || out_pc4 !== 32'(4 * (i + 1))) begin
        errors++; $display("FAIL drain_%0d got %h/%h want %h/%h", i, out_instr, out_pc4, ins[i], 32'(4 * (i + 1)));
      end
      drive(0, 1, 0, 0, 0);
      cycle();
    end
    checks++;
    if (empty !== 1'b1 || out_instr !== 32'h0 || dutv() !== expv()) begin
      errors++; $display("FAIL drained got %h want %h", dutv(), expv());
    end
  endtask

  task automatic test_simul_wrap();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, $urandom, $urandom);
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, $urandom, $urandom);
      cycle();
      checks++;
      if (count !== 3'd2 || dutv() !== expv()) begin
        errors++; $display("FAIL simul_%0d got %h want %h", i, dutv(), expv());
      end
    end
  endtask

  task automatic test_flush();
    drive(0, 0, 1, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, $urandom, $urandom); cycle(); end
    drive(1, 1, 1, 32'h24, 32'h11000002);
    cycle();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_instr !== 32'h0 || out_pc4 !== 32'h0) begin
      errors++; $display("FAIL flush_clear count %0d empty %b instr %h want 0 1 0", count, empty, out_instr);
    end
    drive(1, 0, 0, 32'h28, 32'h2008000A);
    cycle();
    checks++;
    if (out_instr !== 32'h2008000A || out_pc4 !== 32'h28 || count !== 3'd1) begin
      errors++; $display("FAIL flush_target got %h/%h cnt %0d want 2008000a/28 1", out_instr, out_pc4, count);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, $urandom, $urandom);
      cycle();
      checks++;
      if (empty !== 1'b1 || count !== 3'd0) begin
        errors++; $display("FAIL flush_consec_%0d empty %b count %0d want 1 0", i, empty, count);
      end
    end
  endtask

  task automatic test_decode_hold();
    logic [31:0] first;
    drive(0, 0, 1, 0, 0); cycle();
    first = $urandom;
    drive(1, 0, 0, 32'h100, first); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, $urandom, $urandom);
      cycle();
      checks++;
      if (out_instr !== first || count !== 3'((i + 2) > 4 ? 4 : (i + 2)) || dutv() !== expv()) begin
        errors++; $display("FAIL hold_%0d head %h cnt %0d want %h %0d", i, out_instr, count, first, (i + 2) > 4 ? 4 : (i + 2));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, $urandom, $urandom); cycle(); end
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    mq.delete();
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL async_reset count %0d valid %b want 0 0", count, out_valid);
    end
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 0, 32'h44, 32'h20080001);
    cycle();
    checks++;
    if (out_instr !== 32'h20080001 || out_pc4 !== 32'h44 || count !== 3'd1) begin
      errors++; $display("FAIL post_reset_push got %h/%h cnt %0d want 20080001/44 1", out_instr, out_pc4, count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom, $urandom);
      cycle();
      checks++;
      if (dutv() !== expv()) begin
        errors++; $display("FAIL random_%0d got %h want %h", i, dutv(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_wrap();
    test_flush();
    test_decode_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
